// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream for fifo_stream_reader.
// master = reader side, slave = FIFO + consumer side.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_underflow;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: read credits + 2-entry skid buffer feeding a valid/ready stream.
// Optional macro UNDERFLOW_CHK_EN adds the sticky err_underflow output.
module fifo_stream_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    fifo_stream_reader_if.master   bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       words_out
`ifdef UNDERFLOW_CHK_EN
    ,
    output logic                   err_underflow
`endif
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [2];
    logic [CNT_W-1:0]  r_words;

    logic              w_pop;
    logic              w_rd_en;
    logic [1:0]        w_level;
    logic              w_wr_idx;

    // Occupancy after this cycle; a read is allowed only if its word is sure to find a slot.
    assign w_pop    = (r_occ != 2'd0) && bus.m_ready;
    assign w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd_en  = (r_state == RUN) && !bus.fifo_empty && (w_level < 2'd2);
    assign w_wr_idx = (r_occ == 2'd1) && !w_pop;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = (r_occ != 2'd0);
    assign bus.m_data     = r_buf[0];
    assign busy           = (r_state != IDLE);
    assign words_out      = r_words;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_state_next = RUN;
            RUN:     if (!enable) w_state_next = FLUSH;
            FLUSH: begin
                if (enable)
                    w_state_next = RUN;
                else if ((r_occ == 2'd0) && !r_inflight && !w_pop)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_words    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_occ      <= w_level;
            r_inflight <= w_rd_en;
            if (w_pop)
                r_words <= r_words + 1'b1;
        end
    end

    // Pop shifts the tail to the head; an arriving word then lands in the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            if (w_pop)
                r_buf[0] <= r_buf[1];
            if (r_inflight)
                r_buf[w_wr_idx] <= bus.fifo_data_out;
        end
    end

`ifdef UNDERFLOW_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if ((r_inflight && bus.fifo_underflow) || (w_rd_en && bus.fifo_empty))
            r_err <= 1'b1;
    end

    assign err_underflow = r_err;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO model, vector table and corner sequences.
module tb_fifo_stream_reader;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] words_out;
`ifdef UNDERFLOW_CHK_EN
    logic        err_underflow;
`endif

    int unsigned n_vec;
    int unsigned n_fail;
    int unsigned rd_while_empty;

    fifo_stream_reader_if #(.DATA_W(16)) bus ();

    fifo_stream_reader #(
        .DATA_W(16),
        .CNT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bus          (bus),
        .busy         (busy),
        .words_out    (words_out)
`ifdef UNDERFLOW_CHK_EN
        ,
        .err_underflow(err_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous FIFO model: data_out is registered one cycle after an accepted read.
    logic [15:0] mem [64];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data_out <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 6'd1;
        end
    end

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_data;
        logic [15:0] exp_words;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic rdy, input logic rs, input logic uf);
        @(negedge clk);
        enable             = en;
        bus.m_ready        = rdy;
        rst                = rs;
        bus.fifo_underflow = uf;
        #1;
        if (bus.fifo_rd_en && bus.fifo_empty)
            rd_while_empty++;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic fifo_clear();
        wr_ptr = rd_ptr;
    endtask

    task automatic fifo_load(input logic [15:0] base, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            mem[wr_ptr] = base + 16'(k);
            wr_ptr      = wr_ptr + 6'd1;
        end
    endtask

    initial begin
        logic [15:0] got [$];
        int unsigned nrd;
        int unsigned npop;
        int unsigned hold_bad;
        logic [15:0] last_data;
        logic        seen;

        n_vec          = 0;
        n_fail         = 0;
        rd_while_empty = 0;
        rst            = 1'b1;
        enable         = 1'b0;
        bus.m_ready        = 1'b0;
        bus.fifo_underflow = 1'b0;

        //                 en   rdy  rd   vld  chkd data    words   busy
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'd0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 16'd1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 16'd2, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 16'd3, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd4, 1'b1};

        // Reset state
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset rd_en",     bus.fifo_rd_en, 0);
        chk("reset m_valid",   bus.m_valid,    0);
        chk("reset m_data",    bus.m_data,     0);
        chk("reset busy",      busy,           0);
        chk("reset words_out", words_out,      0);
`ifdef UNDERFLOW_CHK_EN
        chk("reset err",       err_underflow,  0);
`endif

        // Four preloaded words streamed at full rate
        fifo_clear();
        fifo_load(16'h0001, 4);
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].en, tbl[i].rdy, 1'b0, 1'b0);
            chk($sformatf("t1[%0d] rd_en", i),   bus.fifo_rd_en, tbl[i].exp_rd);
            chk($sformatf("t1[%0d] m_valid", i), bus.m_valid,    tbl[i].exp_valid);
            if (tbl[i].chk_data)
                chk($sformatf("t1[%0d] m_data", i), bus.m_data, tbl[i].exp_data);
            chk($sformatf("t1[%0d] words", i),   words_out,      tbl[i].exp_words);
            chk($sformatf("t1[%0d] busy", i),    busy,           tbl[i].exp_busy);
        end
`ifdef UNDERFLOW_CHK_EN
        chk("t1 err", err_underflow, 0);
`endif

        // Back-pressure: 8 words, consumer stalled for 10 cycles
        do_reset();
        fifo_clear();
        fifo_load(16'h0201, 8);
        nrd      = 0;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (bus.fifo_rd_en) nrd++;
            if (i >= 3 && !(bus.m_valid && bus.m_data == 16'h0201)) hold_bad++;
        end
        chk("t2 stalled reads", nrd, 2);
        chk("t2 rd_en low",     bus.fifo_rd_en, 0);
        chk("t2 head held",     hold_bad, 0);
        got.delete();
        for (int i = 0; i < 30 && got.size() < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (bus.fifo_rd_en) nrd++;
            if (bus.m_valid) got.push_back(bus.m_data);
        end
        chk("t2 word count", got.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < got.size())
                chk($sformatf("t2 word[%0d]", k), got[k], 16'h0201 + 16'(k));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2 total reads", nrd, 8);
        chk("t2 words_out",   words_out, 8);

        // Single word: one read, then the empty flag stops reading
        do_reset();
        fifo_clear();
        fifo_load(16'h00AA, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 first read",  bus.fifo_rd_en, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 no 2nd read", bus.fifo_rd_en, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 m_valid",     bus.m_valid, 1);
        chk("t3 m_data",      bus.m_data,  16'h00AA);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 drained",     bus.m_valid, 0);
        chk("t3 words_out",   words_out,   1);
`ifdef UNDERFLOW_CHK_EN
        chk("t3 err", err_underflow, 0);
`endif

        // Flush: enable drops while streaming with one buffered and one in flight
        do_reset();
        fifo_clear();
        fifo_load(16'h0401, 20);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        npop      = 0;
        nrd       = 0;
        seen      = 1'b0;
        last_data = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (busy == 1'b0) seen = 1'b1;
            if (bus.fifo_rd_en) nrd++;
            if (bus.m_valid) begin
                npop++;
                last_data = bus.m_data;
            end
        end
        chk("t4 busy fell",     seen, 1);
        chk("t4 flush pops",    npop, 2);
        chk("t4 flush reads",   nrd,  0);
        chk("t4 last word",     last_data, 16'h0406);
        chk("t4 words_out",     words_out, 6);

        // Reset with a full skid buffer and a read issued in the reset cycle
        do_reset();
        fifo_clear();
        fifo_load(16'h0501, 8);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5 pre-rst valid", bus.m_valid,    1);
        chk("t5 pre-rst read",  bus.fifo_rd_en, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5 m_valid",   bus.m_valid, 0);
        chk("t5 words_out", words_out,   0);
        chk("t5 busy",      busy,        0);
        seen      = 1'b0;
        last_data = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (bus.m_valid) begin
                seen      = 1'b1;
                last_data = bus.m_data;
            end
        end
        chk("t5 delivered",     seen, 1);
        chk("t5 first after rst", last_data, 16'h0504);

`ifdef UNDERFLOW_CHK_EN
        // Underflow flag reported by the FIFO one cycle after a read
        do_reset();
        fifo_clear();
        fifo_load(16'h0601, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6 err before", err_underflow, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6 err set",    err_underflow, 1);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6 err sticky", err_underflow, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6 err cleared", err_underflow, 0);
`endif

        chk("rd_en while empty", rd_while_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous FIFO. It drives the FIFO's rd_en and captures data_out, which arrives one cycle after the read.
- It presents the captured words on a valid/ready stream to a downstream consumer.
- It uses read credits and a 2-entry skid buffer, so downstream back-pressure never causes an underflow or a lost word.
- It sustains one word per cycle.

Parameters:
DATA_W, 16, width of FIFO data and stream data
CNT_W, 16, width of the delivered-word counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
enable  in  1  run request; deasserting it starts a flush
fifo_empty  in  1  FIFO empty flag (combinational from FIFO count)
fifo_rd_en  out  1  FIFO read strobe
fifo_data_out  in  DATA_W  FIFO read data, valid the cycle after an accepted read
fifo_underflow  in  1  FIFO underflow flag (used only with the optional feature)
m_valid  out  1  stream word valid
m_ready  in  1  consumer accepts the word
m_data  out  DATA_W  stream data (head of the skid buffer)
busy  out  1  state != IDLE
words_out  out  CNT_W  count of words delivered (m_valid && m_ready)
err_underflow  out  1  sticky error flag; present only with UNDERFLOW_CHK_EN

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk only.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, words_out=0, err_underflow=0. Reset also sets occ=0, inflight=0, state=IDLE.
- Reset mid-operation discards buffered and in-flight words. A fifo_data_out arriving the cycle after reset is ignored.
- Internal state:
  - occ: 0..2, skid buffer occupancy.
  - inflight: 1 bit, set the cycle after fifo_rd_en was high.
  - pop = m_valid && m_ready.
- fifo_rd_en (combinational) = (state==RUN) && !fifo_empty && (occ + inflight - pop < 2).
  - The m_ready-to-fifo_rd_en path is intentional; it gives full throughput.
  - fifo_rd_en is never asserted while fifo_empty=1.
- inflight_next = fifo_rd_en. When inflight=1, fifo_data_out is written into the buffer tail in that same cycle.
- occ_next = occ + inflight - pop. Simultaneous arrival and pop at occ=1 keeps occ=1. Buffer ordering is FIFO.
- The buffer never overflows by construction. occ=2 together with inflight=1 is unreachable.
- m_valid = (occ!=0). m_data is the head entry. m_data is held stable while m_valid && !m_ready.
- Latency: first m_valid is asserted 2 cycles after the first fifo_rd_en. With m_ready held high and a non-empty FIFO, the stream delivers one word per cycle.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> FLUSH when enable=0. No new reads are issued in FLUSH.
  - FLUSH -> IDLE when occ==0, inflight==0 and no pop is pending; buffered and in-flight words are still delivered first.
  - FLUSH -> RUN if enable is reasserted.
- words_out increments by 1 on each pop and wraps modulo 2^CNT_W.

Optional Feature:
- Macro: UNDERFLOW_CHK_EN.
- Defined:
  - err_underflow port exists.
  - It is set when fifo_underflow=1 in the cycle after fifo_rd_en=1, or when fifo_rd_en=1 coincides with fifo_empty=1 (an internal check).
  - It is sticky until rst.
- Undefined:
  - The port and the logic are absent.
  - fifo_underflow is left unused.

Test Plan:
- FIFO preloaded with 0x0001..0x0004, enable=1, m_ready=1:
  - fifo_rd_en is high for 4 consecutive cycles.
  - m_data shows 0x0001..0x0004 on 4 consecutive cycles, starting 2 cycles after the first read.
  - words_out=4. No rd_en while empty.
- FIFO holds 8 words, m_ready=0 for 10 cycles, then 1:
  - Exactly 2 reads are issued, then fifo_rd_en stays low.
  - m_data is held at word 1.
  - After release, all 8 words arrive in order with no loss or duplicate.
- FIFO holds 1 word, m_ready=1:
  - One read is issued; fifo_rd_en=0 on the next cycle (fifo_empty=1).
  - With UNDERFLOW_CHK_EN defined, err_underflow stays 0.
- Streaming at 1 word/cycle, then enable deasserted with occ=1 and inflight=1:
  - Exactly 2 more words are delivered, then busy falls.
  - No read is issued after the enable drop.
- rst asserted for 1 cycle while occ=2:
  - The next cycle shows m_valid=0, words_out=0, busy=0.
  - The word returned from the pre-reset read is not delivered.
- With UNDERFLOW_CHK_EN defined, force fifo_underflow=1 the cycle after a read:
  - err_underflow goes to 1 and stays 1 until rst.
